alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Upstream front-end for the lab's 4-bit ALU. Sequentially captures operand A, operand B and the opcode from a shared 4-bit switch bus, one value per button press.
- Holds all three values stable on registered outputs that drive the ALU's A, B and OpCode inputs.
- Flags when the ALU result is meaningful (valid), when the opcode is unsupported, and when a division by zero is requested.

Parameters:
- WIDTH, 4, operand width; sw, a_out and b_out are WIDTH bits.
- OPW, 4, opcode width.
- DEBOUNCE_CYCLES, 250000, stable-high cycles required per press; used only when DEBOUNCE_EN is defined; must be ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  WIDTH  raw switch value; the low OPW bits are used as the opcode.
- btn_load  input  1  raw, asynchronous load pushbutton, active-high.
- btn_clear  input  1  raw, asynchronous clear pushbutton, active-high.
- a_out  output  WIDTH  registered operand A to the ALU.
- b_out  output  WIDTH  registered operand B to the ALU.
- op_out  output  OPW  registered opcode to the ALU.
- valid  output  1  high only in state READY.
- op_illegal  output  1  high when op_out is not one of 0000–0101 or 1000–1010.
- div_zero  output  1  high when op_out==0011 and b_out==0, in READY only.
- state_o  output  2  current state for LEDs: 00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 READY.

Behaviour:
- Reset (rst high at a clk edge):
  - a_out, b_out and op_out go to 0.
  - valid, op_illegal and div_zero go to 0.
  - State goes to LOAD_A; synchronizer and debounce state are cleared.
  - Reset mid-sequence discards any partial load.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector that produces a 1-cycle pulse (load_p, clear_p).
  - Without debounce, capture occurs on the 3rd rising clk edge at which btn_load is sampled high.
  - Exactly one pulse per press. Holding the button produces no repeats; the button must be seen low before the next pulse.
- FSM (advances only on load_p):
  - LOAD_A: a_out ← sw → LOAD_B.
  - LOAD_B: b_out ← sw → LOAD_OP.
  - LOAD_OP: op_out ← sw[OPW-1:0] → READY.
  - READY: a_out ← sw, b_out ← 0, op_out ← 0 → LOAD_B. This starts a new operation; valid drops the same cycle.
- clear_p: from any state, zero all three registers → LOAD_A.
- Simultaneous clear_p and load_p: clear wins; no capture.
- Registers not being loaded hold their value.
- Status outputs:
  - valid is registered; it is 1 in the cycle after the LOAD_OP capture edge.
  - op_illegal is combinational from op_out, in every state.
  - div_zero is combinational: (state==READY) & (op_out==0011) & (b_out==0).
- No arithmetic is performed; values pass through unmodified. sw bits above OPW are ignored for the opcode.

Optional Feature:
- Macro: ALU_LOADER_DEBOUNCE_EN.
- Defined: each synchronized button feeds a counter.
  - The counter increments while the input is high and resets to 0 whenever it is low.
  - The pulse fires once, on the cycle the count reaches DEBOUNCE_CYCLES. No further pulse until the input returns low.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: no counter; the edge detector drives the pulse directly (latency above).

Test Plan:
- Reset then idle → all outputs 0, state_o=00, op_illegal=0 (op 0000 is legal).
- sw=0101 press; sw=0011 press; sw=0000 press → a_out=5, b_out=3, op_out=0000, valid=1, state_o=11. The ALU result 8 is checked downstream.
- Full load A=7, B=0, op=0011 → div_zero=1, valid=1. Then load A=2 → valid=0, div_zero=0, b_out=0, op_out=0, state_o=01.
- Load op=1100 → op_illegal=1. Load op=1010 on the next sequence → op_illegal=0.
- btn_load held high 20 cycles in LOAD_A → exactly one capture, state_o=01. Same-cycle clear+load in LOAD_OP → registers 0, state_o=00.
- DEBOUNCE_EN with DEBOUNCE_CYCLES=4: a 3-cycle pulse → no capture; a 6-cycle pulse → one capture, 4 cycles after the synchronized rise.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Operand/opcode front-end for the 4-bit lab ALU: captures A, B and opcode from a shared switch bus.
// Optional button debounce is enabled by defining ALU_LOADER_DEBOUNCE_EN.
module alu_operand_loader #(
    parameter int WIDTH           = 4,
    parameter int OPW             = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [OPW-1:0]   op_out,
    output logic             valid,
    output logic             op_illegal,
    output logic             div_zero,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        READY   = 2'b11
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_range_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [OPW-1:0]   r_op, w_op_next;
    logic             r_valid;
    logic [1:0]       r_load_sync;
    logic [1:0]       r_clear_sync;
    logic             w_load_lvl;
    logic             w_clear_lvl;
    logic             w_load_p;
    logic             w_clear_p;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_sync  <= '0;
            r_clear_sync <= '0;
        end else begin
            r_load_sync  <= {r_load_sync[0], btn_load};
            r_clear_sync <= {r_clear_sync[0], btn_clear};
        end
    end

    assign w_load_lvl  = r_load_sync[1];
    assign w_clear_lvl = r_clear_sync[1];

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_load_cnt;
    logic [CW-1:0] r_clear_cnt;

    // Counters saturate at DEBOUNCE_CYCLES so a held button fires only once.
    always_ff @(posedge clk) begin
        if (rst || !w_load_lvl) begin
            r_load_cnt <= '0;
        end else if (r_load_cnt != CW'(DEBOUNCE_CYCLES)) begin
            r_load_cnt <= r_load_cnt + CW'(1);
        end
        if (rst || !w_clear_lvl) begin
            r_clear_cnt <= '0;
        end else if (r_clear_cnt != CW'(DEBOUNCE_CYCLES)) begin
            r_clear_cnt <= r_clear_cnt + CW'(1);
        end
    end

    assign w_load_p  = w_load_lvl  && (r_load_cnt  == CW'(DEBOUNCE_CYCLES - 1));
    assign w_clear_p = w_clear_lvl && (r_clear_cnt == CW'(DEBOUNCE_CYCLES - 1));
`else
    logic r_load_prev;
    logic r_clear_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_prev  <= 1'b0;
            r_clear_prev <= 1'b0;
        end else begin
            r_load_prev  <= w_load_lvl;
            r_clear_prev <= w_clear_lvl;
        end
    end

    assign w_load_p  = w_load_lvl  && !r_load_prev;
    assign w_clear_p = w_clear_lvl && !r_clear_prev;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        if (w_clear_p) begin
            w_state_next = LOAD_A;
            w_a_next     = '0;
            w_b_next     = '0;
            w_op_next    = '0;
        end else if (w_load_p) begin
            case (r_state)
                LOAD_A: begin
                    w_a_next     = sw;
                    w_state_next = LOAD_B;
                end
                LOAD_B: begin
                    w_b_next     = sw;
                    w_state_next = LOAD_OP;
                end
                LOAD_OP: begin
                    w_op_next    = sw[OPW-1:0];
                    w_state_next = READY;
                end
                READY: begin
                    // A press in READY begins the next operation with a fresh A.
                    w_a_next     = sw;
                    w_b_next     = '0;
                    w_op_next    = '0;
                    w_state_next = LOAD_B;
                end
                default: w_state_next = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_valid <= (w_state_next == READY);
        end
    end

    assign a_out      = r_a;
    assign b_out      = r_b;
    assign op_out     = r_op;
    assign valid      = r_valid;
    assign state_o    = r_state;
    assign op_illegal = !((r_op <= OPW'(5)) || ((r_op >= OPW'(8)) && (r_op <= OPW'(10))));
    assign div_zero   = (r_state == READY) && (r_op == OPW'(3)) && (r_b == '0);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader (default build, no debounce).
// Expected output sets are queued when a step is driven and compared once the step settles.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       btn_load;
    logic       btn_clear;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [3:0] op_out;
    logic       valid;
    logic       op_illegal;
    logic       div_zero;
    logic [1:0] state_o;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       vld;
        logic       ill;
        logic       dz;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_load   (btn_load),
        .btn_clear  (btn_clear),
        .a_out      (a_out),
        .b_out      (b_out),
        .op_out     (op_out),
        .valid      (valid),
        .op_illegal (op_illegal),
        .div_zero   (div_zero),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic legal_op(input logic [3:0] op);
        return (op inside {[4'd0:4'd5], [4'd8:4'd10]});
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] op, input logic [1:0] st);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = op;
        e.st  = st;
        e.vld = (st == 2'b11);
        e.ill = !legal_op(op);
        e.dz  = (st == 2'b11) && (op == 4'd3) && (b == 4'd0);
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".a"},     a_out,            e.a);
            check({tag, ".b"},     b_out,            e.b);
            check({tag, ".op"},    op_out,           e.op);
            check({tag, ".valid"}, {3'b0, valid},    {3'b0, e.vld});
            check({tag, ".ill"},   {3'b0, op_illegal}, {3'b0, e.ill});
            check({tag, ".dz"},    {3'b0, div_zero}, {3'b0, e.dz});
            check({tag, ".state"}, {2'b0, state_o},  {2'b0, e.st});
        end
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        sw       = v;
        btn_load = 1'b1;
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_clear();
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (3) @(negedge clk);
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        sw        = 4'h0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_state(4'd0, 4'd0, 4'd0, 2'b00);
        check_out("reset_idle");

        // Basic A=5, B=3, op=0000 sequence.
        press(4'd5); expect_state(4'd5, 4'd0, 4'd0, 2'b01); check_out("load_a5");
        press(4'd3); expect_state(4'd5, 4'd3, 4'd0, 2'b10); check_out("load_b3");
        press(4'd0); expect_state(4'd5, 4'd3, 4'd0, 2'b11); check_out("load_op0");

        // Divide by zero, then a new operation from READY.
        press(4'd7); expect_state(4'd7, 4'd0, 4'd0, 2'b01); check_out("ready_new_a7");
        press(4'd0); expect_state(4'd7, 4'd0, 4'd0, 2'b10); check_out("load_b0");
        press(4'd3); expect_state(4'd7, 4'd0, 4'd3, 2'b11); check_out("div_zero");
        press(4'd2); expect_state(4'd2, 4'd0, 4'd0, 2'b01); check_out("ready_new_a2");

        // Divide with non-zero B does not flag.
        press(4'd4); expect_state(4'd2, 4'd4, 4'd0, 2'b10); check_out("load_b4");
        press(4'd3); expect_state(4'd2, 4'd4, 4'd3, 2'b11); check_out("div_nonzero");

        // Illegal 1100, then legal 1010 on the next sequence.
        press(4'd1);  expect_state(4'd1, 4'd0, 4'd0,  2'b01); check_out("seq3_a");
        press(4'd6);  expect_state(4'd1, 4'd6, 4'd0,  2'b10); check_out("seq3_b");
        press(4'hC);  expect_state(4'd1, 4'd6, 4'hC,  2'b11); check_out("op_1100");
        press(4'd9);  expect_state(4'd9, 4'd0, 4'd0,  2'b01); check_out("seq4_a");
        press(4'd1);  expect_state(4'd9, 4'd1, 4'd0,  2'b10); check_out("seq4_b");
        press(4'hA);  expect_state(4'd9, 4'd1, 4'hA,  2'b11); check_out("op_1010");

        // Clear from READY.
        press_clear(); expect_state(4'd0, 4'd0, 4'd0, 2'b00); check_out("clear_ready");

        // Sweep every opcode through a full sequence.
        for (int op = 0; op < 16; op++) begin
            press(4'(op));
            if (op == 0) expect_state(4'(op), 4'd0, 4'd0, 2'b01);
            else         expect_state(4'(op), 4'd0, 4'd0, 2'b01);
            check_out("sweep_a");
            press(4'(op) ^ 4'hF); expect_state(4'(op), 4'(op) ^ 4'hF, 4'd0, 2'b10); check_out("sweep_b");
            press(4'(op));        expect_state(4'(op), 4'(op) ^ 4'hF, 4'(op), 2'b11); check_out("sweep_op");
        end
        press_clear(); expect_state(4'd0, 4'd0, 4'd0, 2'b00); check_out("clear_sweep");

        // Capture latency: nothing after two sampling edges, capture on the third.
        @(negedge clk);
        sw       = 4'd9;
        btn_load = 1'b1;
        repeat (2) @(negedge clk);
        check("latency_edge2.a", a_out, 4'd0);
        check("latency_edge2.state", {2'b0, state_o}, 4'd0);
        @(negedge clk);
        check("latency_edge3.a", a_out, 4'd9);
        check("latency_edge3.state", {2'b0, state_o}, 4'd1);

        // Keep holding for 20 cycles total with a new switch value: no repeat capture.
        repeat (5) @(negedge clk);
        sw = 4'd6;
        repeat (12) @(negedge clk);
        btn_load = 1'b0;
        repeat (3) @(negedge clk);
        expect_state(4'd9, 4'd0, 4'd0, 2'b01); check_out("hold_single");

        // Simultaneous clear and load in LOAD_OP: clear wins.
        press(4'd6); expect_state(4'd9, 4'd6, 4'd0, 2'b10); check_out("pre_simul");
        @(negedge clk);
        sw        = 4'd5;
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        repeat (3) @(negedge clk);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        expect_state(4'd0, 4'd0, 4'd0, 2'b00); check_out("simul_clear_load");

        // Reset mid-sequence discards the partial load.
        press(4'd8); expect_state(4'd8, 4'd0, 4'd0, 2'b01); check_out("pre_reset");
        press(4'd2); expect_state(4'd8, 4'd2, 4'd0, 2'b10); check_out("pre_reset_b");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_state(4'd0, 4'd0, 4'd0, 2'b00); check_out("mid_reset");

        check("scoreboard_drained", 4'(exp_q.size()), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
